// File: rtl/program_loader.sv
// Byte-stream boot loader: unpacks framed bytes into program-memory writes
// and holds the core off the text RAM while a frame is in flight.
module program_loader #(
    parameter int ADDR    = 8,
    parameter int CODE    = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   program_write,
    output logic [ADDR+CODE-1:0]   program_cmd,
    output logic [ADDR-1:0]        prog_addr,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);

    localparam int WORD = ADDR + CODE;
    localparam int HIW  = WORD - 8;
    localparam int RW   = ADDR + 1;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [15:0]   HI_MASK = 16'hFF << HIW;
    localparam logic [7:0]    HI_BAD  = HI_MASK[7:0];
    localparam logic [RW-1:0] NWORDS  = RW'(1) << ADDR;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_e;

    state_e          state_q, state_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [7:0]      chk_q, chk_d;
    logic [HIW-1:0]  hi_q, hi_d;
    logic [7:0]      lo_q, lo_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            xfer;
    logic            timed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            chk_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            chk_q   <= chk_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            tmo_q   <= tmo_d;
        end
    end

    assign xfer  = in_valid && in_ready;
    assign timed = (state_q == S_COUNT) || (state_q == S_HI) ||
                   (state_q == S_LO) || (state_q == S_CHECK);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        chk_d   = chk_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        tmo_d   = '0;
        // Idle gap inside a frame; any accepted byte restarts the count
        if (timed && !xfer) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TW'(TIMEOUT - 1)) state_d = S_ERROR;
        end
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (xfer && in_data == 8'hA5) begin
                    state_d = S_COUNT;
                    addr_d  = '0;
                    chk_d   = '0;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    chk_d = chk_q ^ in_data;
                    if (32'(in_data) > 32'(NWORDS)) begin
                        state_d = S_ERROR;
                    end else begin
                        rem_d   = (in_data == 8'h00) ? NWORDS : RW'(in_data);
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    if ((in_data & HI_BAD) != 8'h00) begin
                        state_d = S_ERROR;
                    end else begin
                        hi_d    = in_data[HIW-1:0];
                        chk_d   = chk_q ^ in_data;
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == RW'(1)) ? S_CHECK : S_HI;
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = (in_data == chk_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_q != S_WRITE);
        program_write = (state_q == S_WRITE);
        cpu_hold      = timed || (state_q == S_WRITE);
        done          = (state_q == S_DONE);
        error         = (state_q == S_ERROR);
        program_cmd   = {hi_q, lo_q};
        prog_addr     = addr_q;
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames against a frame-level reference model.
module tb_program_loader;

    localparam int ADDR    = 8;
    localparam int CODE    = 4;
    localparam int TIMEOUT = 1000;
    localparam int WORD    = ADDR + CODE;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             program_write;
    logic [WORD-1:0]  program_cmd;
    logic [ADDR-1:0]  prog_addr;
    logic             cpu_hold;
    logic             done;
    logic             error;

    int ncmp  = 0;
    int nfail = 0;

    logic [ADDR+WORD-1:0] wq[$];
    logic [ADDR+WORD-1:0] ew[$];
    logic [7:0]           fb[$];

    always #5 clk = ~clk;

    program_loader #(.ADDR(ADDR), .CODE(CODE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .program_write(program_write),
        .program_cmd(program_cmd), .prog_addr(prog_addr),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (program_write) begin
            wq.push_back({prog_addr, program_cmd});
            check("ready_in_write", 32'(in_ready), 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the byte is taken
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        bit got;
        got = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 8; k++) begin
            ok = in_ready;
            @(negedge clk);
            if (ok) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ready_stuck", 32'(got), 32'd1);
    endtask

    task automatic build(input int n, input bit bad_chk, input int bad_hi,
                         output bit exp_ok);
        int words;
        logic [7:0] chk;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [WORD-1:0] c;
        fb.delete();
        ew.delete();
        words = (n == 0) ? (1 << ADDR) : n;
        chk = 8'(n);
        fb.push_back(8'hA5);
        fb.push_back(8'(n));
        for (int i = 0; i < words; i++) begin
            c  = WORD'($urandom);
            hi = 8'(c >> 8);
            lo = c[7:0];
            if (i == bad_hi) begin
                fb.push_back(hi | 8'h80);
                exp_ok = 1'b0;
                return;
            end
            fb.push_back(hi);
            fb.push_back(lo);
            chk = chk ^ hi ^ lo;
            ew.push_back({ADDR'(i % (1 << ADDR)), c});
        end
        if (bad_chk) chk = chk ^ 8'($urandom_range(1, 255));
        fb.push_back(chk);
        exp_ok = !bad_chk;
    endtask

    task automatic play(input string tag, input bit exp_ok, input bit stuck);
        int gap;
        int m;
        wq.delete();
        foreach (fb[i]) begin
            if (stuck) gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            else       gap = $urandom_range(0, 3);
            send_byte(fb[i], gap);
            if (i == 0) begin
                check({tag, ".hold_on"}, 32'(cpu_hold), 32'd1);
                check({tag, ".done_clr"}, 32'(done), 32'd0);
            end
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, ".nwr"}, wq.size(), ew.size());
        m = (wq.size() < ew.size()) ? wq.size() : ew.size();
        for (int i = 0; i < m; i++)
            check($sformatf("%s.wr%0d", tag, i), 32'(wq[i]), 32'(ew[i]));
        check({tag, ".done"}, 32'(done), 32'(exp_ok));
        check({tag, ".error"}, 32'(error), 32'(!exp_ok));
        check({tag, ".hold_off"}, 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.write", 32'(program_write), 32'd0);
        check("rst.cmd", 32'(program_cmd), 32'd0);
        check("rst.addr", 32'(prog_addr), 32'd0);
        check("rst.hold", 32'(cpu_hold), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.error", 32'(error), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd1);

        send_byte(8'h3C, 0);
        in_valid = 1'b0;
        check("junk.hold", 32'(cpu_hold), 32'd0);

        fb = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'hD0};
        ew = '{20'h00123, 20'h01FFF};
        play("dir_ok", 1'b1, 1'b0);

        fb = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h00};
        play("dir_badchk", 1'b0, 1'b0);

        fb = '{8'hA5, 8'h01, 8'hF1};
        ew.delete();
        play("dir_badhi", 1'b0, 1'b0);

        build(0, 1'b0, -1, ok);
        play("full", ok, 1'b1);
        check("full.wrap", 32'(prog_addr), 32'd0);

        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 12);
            build(n, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1, ok);
            play($sformatf("rnd%0d", f), ok, $urandom_range(0, 1) == 1);
        end

        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        in_valid = 1'b0;
        repeat (TIMEOUT - 5) @(negedge clk);
        check("tmo.early", 32'(error), 32'd0);
        check("tmo.hold", 32'(cpu_hold), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (error) begin
                seen = 1'b1;
                break;
            end
        end
        check("tmo.error", 32'(seen), 32'd1);
        send_byte(8'hA5, 0);
        in_valid = 1'b0;
        check("tmo.clr", 32'(error), 32'd0);
        check("tmo.rehold", 32'(cpu_hold), 32'd1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h05, 0);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mrst.write", 32'(program_write), 32'd0);
        check("mrst.cmd", 32'(program_cmd), 32'd0);
        check("mrst.addr", 32'(prog_addr), 32'd0);
        check("mrst.hold", 32'(cpu_hold), 32'd0);
        check("mrst.done", 32'(done), 32'd0);
        check("mrst.error", 32'(error), 32'd0);
        check("mrst.ready", 32'(in_ready), 32'd1);
        send_byte(8'h34, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst.nwr", wq.size(), 32'd0);
        check("mrst.idle_hold", 32'(cpu_hold), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
